// File: rtl/asmd_div.sv
// Sequential restoring unsigned divider: ASMD-style FSM plus shift-subtract datapath.
// Optional ASMD_DIV_EARLY_EN adds an EARLY state that short-circuits a_in < b_in.
module asmd_div #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

`ifdef ASMD_DIV_EARLY_EN
    typedef enum logic [2:0] {StIdle, StDiv0, StLoad, StOp, StEarly} state_e;
`else
    typedef enum logic [2:0] {StIdle, StDiv0, StLoad, StOp} state_e;
`endif

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  quo_q;
    logic [CntW-1:0]   cnt_q;

    logic [WIDTH:0]    shift_val;
    logic [WIDTH-1:0]  diff;
    logic              fits;
    logic [WIDTH-1:0]  rem_nxt;
    logic [WIDTH-1:0]  quo_nxt;

    // The restored remainder is always below the divisor, so only the shifted
    // trial value needs the extra bit.
    always_comb begin
        shift_val = {rem_q, quo_q[WIDTH-1]};
        fits      = shift_val >= {1'b0, b_q};
        diff      = shift_val[WIDTH-1:0] - b_q;
        rem_nxt   = fits ? diff : shift_val[WIDTH-1:0];
        quo_nxt   = {quo_q[WIDTH-2:0], fits};
    end

    assign ready = (state_q == StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q <= a_in;
                        b_q <= b_in;
                        if (b_in == '0) begin
                            state_q <= StDiv0;
`ifdef ASMD_DIV_EARLY_EN
                        end else if (a_in < b_in) begin
                            state_q <= StEarly;
`endif
                        end else begin
                            state_q <= StLoad;
                        end
                    end
                end
                StDiv0: begin
                    q           <= '1;
                    r           <= a_q;
                    div_by_zero <= 1'b1;
                    state_q     <= StIdle;
                end
                StLoad: begin
                    rem_q   <= '0;
                    quo_q   <= a_q;
                    cnt_q   <= CntW'(WIDTH);
                    state_q <= StOp;
                end
                StOp: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        q           <= quo_nxt;
                        r           <= rem_nxt;
                        div_by_zero <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
`ifdef ASMD_DIV_EARLY_EN
                StEarly: begin
                    q           <= '0;
                    r           <= a_q;
                    div_by_zero <= 1'b0;
                    state_q     <= StIdle;
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_asmd_div.sv
// Self-checking bench for asmd_div: directed cases plus random operands against an
// arithmetic reference model (/, %), including latency, hold and handshake checks.
module tb_asmd_div;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         ready;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;
    logic         last_z = 1'b0;

    asmd_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a_in        (a_in),
        .b_in        (b_in),
        .ready       (ready),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic; busy time is 1 cycle for short paths, W+1 otherwise.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] eq, output logic [W-1:0] er,
                         output logic ez, output int elat);
        if (b == 0) begin
            eq = '1; er = a; ez = 1'b1; elat = 1;
        end else begin
            eq = a / b; er = a % b; ez = 1'b0; elat = W + 1;
`ifdef ASMD_DIV_EARLY_EN
            if (a < b) elat = 1;
`endif
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!ready) check("ready_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit pulse);
        logic [W-1:0] eq, er;
        logic ez;
        int elat;
        int n;
        model(a, b, eq, er, ez, elat);
        wait_ready();
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in  = W'($urandom);
        b_in  = W'($urandom);
        n = 0;
        while (!ready && n < 50) begin
            check("hold_q", q, last_q);
            check("hold_r", r, last_r);
            n++;
            if (pulse && n == 3) begin
                start = 1'b1;
                a_in  = 1;
                b_in  = 1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("latency", n, elat);
        check("q", q, eq);
        check("r", r, er);
        check("dbz", div_by_zero, ez);
        last_q = eq;
        last_r = er;
        last_z = ez;
    endtask

    initial begin
        int n;
        logic [W-1:0] ra, rb;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_dbz", div_by_zero, 0);

        run_op(200, 7, 0);
        run_op(255, 1, 0);
        run_op(255, 255, 0);
        run_op(0, 5, 0);
        run_op(13, 0, 0);
        run_op(9, 3, 0);
        run_op(5, 9, 0);

        // Abort mid-operation: outputs must return to reset values.
        wait_ready();
        a_in  = 100;
        b_in  = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_rst", ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_q", q, 0);
        check("abort_r", r, 0);
        check("abort_dbz", div_by_zero, 0);
        last_q = '0;
        last_r = '0;
        last_z = 1'b0;
        run_op(100, 3, 0);

        // Start pulsed while busy must be ignored.
        run_op(200, 7, 1);
        check("after_pulse_ready", ready, 1);
        @(negedge clk);
        check("no_queued_op", ready, 1);

        // Start held high: back-to-back ops, one idle cycle between them.
        wait_ready();
        a_in  = 50;
        b_in  = 6;
        start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!ready && n < 50) begin
                n++;
                @(negedge clk);
            end
            check("b2b_busy", n, W + 1);
            check("b2b_q", q, 8);
            check("b2b_r", r, 2);
            n = 0;
            while (ready && n < 20) begin
                n++;
                @(negedge clk);
            end
            check("b2b_idle", n, 1);
        end
        start = 1'b0;
        wait_ready();
        last_q = q;
        last_r = r;
        check("b2b_final_q", q, 8);

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 8 == 0) rb = '0;
            else if (i % 5 == 0) rb = W'($urandom_range(255, 128));
            else if (i % 3 == 0) rb = W'($urandom_range(15, 1));
            run_op(ra, rb, (i % 7) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
